c_realign_buffer: RTL and testbench

- Parametrised successor to the single-instruction misalignment fixer.
- Halfword-granular fetch buffer between the I-memory fetch port and decode. Supports any mix of 16-bit (RVC) and 32-bit instructions, including 32-bit instructions straddling fetch words.
- Valid/ready handshakes on both sides replace NOP injection and PC stalling.
- Flush to any halfword-aligned target; leading halfwords of the first fetched word are dropped automatically.

---
 rtl/c_realign_buffer_pkg.sv | 26 ++
 rtl/c_realign_buffer_hw_fifo.sv | 75 +++++++
 rtl/c_realign_buffer.sv | 117 +++++++++++
 tb/tb_c_realign_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_realign_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : c_realign_pkg
// Brief   : Shared types, constants and helpers for the halfword realign
//           buffer (state encoding, RVC classification).
// Revision: 1.0 - initial release
// ============================================================================
package c_realign_pkg;

    localparam int         HW_W         = 16;
    localparam logic [1:0] RVC_OPC_FULL = 2'b11;

    // ST_ALIGN: waiting for the first beat after reset/flush (leading halfwords dropped)
    // ST_RUN  : steady-state streaming, every halfword of a beat is kept
    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A halfword starts a compressed instruction unless its low two bits are 2'b11
    function automatic logic is_rvc(input logic [HW_W-1:0] hw);
        return (hw & {{(HW_W-2){1'b0}}, RVC_OPC_FULL}) != {{(HW_W-2){1'b0}}, RVC_OPC_FULL};
    endfunction

endpackage : c_realign_pkg
`default_nettype wire

// File: rtl/c_realign_buffer_hw_fifo.sv
`default_nettype none
// ============================================================================
// Module  : c_hw_fifo
// Brief   : Circular halfword buffer. Accepts 0..FETCH_HW halfwords per cycle,
//           releases 0..2 per cycle, exposes occupancy and the two head
//           entries. Depth need not be a power of two.
// Revision: 1.0 - initial release
// ============================================================================
module c_hw_fifo
    import c_realign_pkg::*;
#(
    parameter int FETCH_HW = 2,
    parameter int DEPTH_HW = 6,
    localparam int PW  = (DEPTH_HW > 1) ? $clog2(DEPTH_HW) : 1,
    localparam int CW  = $clog2(DEPTH_HW + 1),
    localparam int PCW = $clog2(FETCH_HW + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic [HW_W*FETCH_HW-1:0] i_push_data,
    input  logic [PCW-1:0]           i_push_cnt,
    input  logic [1:0]               i_pop_cnt,
    output logic [CW-1:0]            o_count,
    output logic [HW_W-1:0]          o_hw0,
    output logic [HW_W-1:0]          o_hw1
);

    logic [HW_W-1:0] r_mem [DEPTH_HW];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;

    // Modulo-DEPTH_HW reduction; callers never exceed 2*DEPTH_HW-1
    function automatic logic [PW-1:0] f_wrap(input logic [PW:0] v);
        if (v >= (PW+1)'(DEPTH_HW))
            return PW'(v - (PW+1)'(DEPTH_HW));
        else
            return PW'(v);
    endfunction

    logic [PW-1:0] w_rd_p1;
    assign w_rd_p1 = f_wrap({1'b0, r_rd} + (PW+1)'(1));

    // Storage writes: halfword j of the (already shifted) beat lands at wr+j
    always_ff @(posedge clk) begin
        for (int j = 0; j < FETCH_HW; j++) begin
            if (!i_clear && (PCW'(j) < i_push_cnt))
                r_mem[f_wrap({1'b0, r_wr} + (PW+1)'(j))] <= i_push_data[j*HW_W +: HW_W];
        end
    end

    // Pointer and occupancy bookkeeping; clear wins over concurrent push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= f_wrap({1'b0, r_rd} + (PW+1)'(i_pop_cnt));
            r_wr    <= f_wrap({1'b0, r_wr} + (PW+1)'(i_push_cnt));
            r_count <= r_count + CW'(i_push_cnt) - CW'(i_pop_cnt);
        end
    end

    assign o_count = r_count;
    assign o_hw0   = r_mem[r_rd];
    assign o_hw1   = r_mem[w_rd_p1];

endmodule : c_hw_fifo
`default_nettype wire

// File: rtl/c_realign_buffer.sv
`default_nettype none
// ============================================================================
// Module  : c_realign_buffer
// Brief   : Halfword-granular fetch buffer between I-memory and decode.
//           Reassembles mixed 16/32-bit instructions (including ones that
//           straddle fetch words), drops leading halfwords after a redirect,
//           and uses valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module c_realign_buffer
    import c_realign_pkg::*;
#(
    parameter int          FETCH_HW = 2,
    parameter int          DEPTH_HW = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic [31:0]              flush_pc_i,
    input  logic                     fetch_valid_i,
    input  logic [HW_W*FETCH_HW-1:0] fetch_data_i,
    output logic                     fetch_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              pc_o,
    output logic                     is_compressed_o
);

    localparam int CW  = $clog2(DEPTH_HW + 1);
    localparam int PCW = $clog2(FETCH_HW + 1);
    // Drop index width: halfword position of a PC inside one fetch word
    localparam int DW  = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
    localparam logic [DW-1:0] c_RESET_DROP = (FETCH_HW > 1) ? RESET_PC[DW:1] : '0;

    state_t          r_state;
    logic [DW-1:0]   r_drop;
    logic [31:0]     r_head_pc;

    logic [CW-1:0]   w_count;
    logic [HW_W-1:0] w_hw0;
    logic [HW_W-1:0] w_hw1;
    logic            w_head_rvc;
    logic            w_push;
    logic            w_pop;
    logic [PCW-1:0]  w_push_cnt;
    logic [1:0]      w_pop_cnt;
    logic [HW_W*FETCH_HW-1:0] w_push_data;
    logic [31:0]     w_flush_pc;
    logic [DW-1:0]   w_flush_drop;
    logic [DW-1:0]   w_shift_hw;

    // Redirect target with bit 0 forced low (halfword alignment)
    assign w_flush_pc = flush_pc_i & 32'hFFFF_FFFE;

    if (FETCH_HW > 1) begin : g_drop
        assign w_flush_drop = w_flush_pc[DW:1];
    end else begin : g_no_drop
        assign w_flush_drop = '0;
    end

    // Head classification and delivery handshake
    assign w_head_rvc  = is_rvc(w_hw0);
    assign out_valid_o = (w_count != '0) && (w_head_rvc || (w_count >= CW'(2)));
    assign w_pop       = out_valid_o && out_ready_i && !flush_i;
    assign w_pop_cnt   = w_pop ? (w_head_rvc ? 2'd1 : 2'd2) : 2'd0;

    // Fetch side: only a full beat of free space grants ready (no pop credit)
    assign fetch_ready_o = (w_count <= CW'(DEPTH_HW - FETCH_HW)) && !reset;
    assign w_push        = fetch_valid_i && fetch_ready_o && !flush_i;
    assign w_shift_hw    = (r_state == ST_ALIGN) ? r_drop : '0;
    assign w_push_data   = fetch_data_i >> (HW_W * int'(w_shift_hw));
    assign w_push_cnt    = w_push ? (PCW'(FETCH_HW) - PCW'(w_shift_hw)) : '0;

    assign inst_o          = !out_valid_o ? NOP_INST
                           : w_head_rvc   ? {16'h0000, w_hw0}
                           :                {w_hw1, w_hw0};
    assign pc_o            = r_head_pc;
    assign is_compressed_o = out_valid_o && w_head_rvc;

    c_hw_fifo #(
        .FETCH_HW (FETCH_HW),
        .DEPTH_HW (DEPTH_HW)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (flush_i),
        .i_push_data (w_push_data),
        .i_push_cnt  (w_push_cnt),
        .i_pop_cnt   (w_pop_cnt),
        .o_count     (w_count),
        .o_hw0       (w_hw0),
        .o_hw1       (w_hw1)
    );

    // Align/run FSM, drop count and head PC tracking; flush has top priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_ALIGN;
            r_drop    <= c_RESET_DROP;
            r_head_pc <= RESET_PC;
        end else if (flush_i) begin
            r_state   <= ST_ALIGN;
            r_drop    <= w_flush_drop;
            r_head_pc <= w_flush_pc;
        end else begin
            if (r_state == ST_ALIGN && w_push)
                r_state <= ST_RUN;
            if (w_pop)
                r_head_pc <= r_head_pc + (w_head_rvc ? 32'd2 : 32'd4);
        end
    end

endmodule : c_realign_buffer
`default_nettype wire

// File: tb/tb_c_realign_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_c_realign_buffer
// Brief   : Directed self-checking bench for c_realign_buffer
//           (FETCH_HW = 2, DEPTH_HW = 6, RESET_PC = 0).
// Revision: 1.0 - initial release
// ============================================================================
module tb_c_realign_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_data_i;
    logic        fetch_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        is_compressed_o;

    int checks = 0;
    int errors = 0;

    c_realign_buffer #(
        .FETCH_HW (2),
        .DEPTH_HW (6),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_data_i    (fetch_data_i),
        .fetch_ready_o   (fetch_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .is_compressed_o (is_compressed_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled at negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || inst_o !== 32'h13 ||
            pc_o !== 32'h0 || is_compressed_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b fr=%b inst=%h pc=%h c=%b, want v=0 fr=0 inst=00000013 pc=00000000 c=0",
                     out_valid_o, fetch_ready_o, inst_o, pc_o, is_compressed_o);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", fetch_ready_o);
        end
    endtask

    task automatic test_aligned();
        @(negedge clk);
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h00A0_0513;
        step();
        fetch_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || pc_o !== 32'h0 || is_compressed_o !== 1'b0) begin
            errors++;
            $display("FAIL aligned_word: got v=%b inst=%h pc=%h c=%b, want v=1 inst=00a00513 pc=00000000 c=0",
                     out_valid_o, inst_o, pc_o, is_compressed_o);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h4) begin
            errors++;
            $display("FAIL aligned_pop: got v=%b pc=%h, want v=0 pc=00000004", out_valid_o, pc_o);
        end
    endtask

    task automatic test_straddle();
        flush_i    = 1'b1;
        flush_pc_i = 32'h0;
        step();
        flush_i = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0513_4501;
        out_ready_i   = 1'b1;
        step();
        fetch_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h0000_4501 || pc_o !== 32'h0 || is_compressed_o !== 1'b1) begin
            errors++;
            $display("FAIL straddle_c0: got v=%b inst=%h pc=%h c=%b, want v=1 inst=00004501 pc=00000000 c=1",
                     out_valid_o, inst_o, pc_o, is_compressed_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h2 || inst_o !== 32'h13) begin
            errors++;
            $display("FAIL straddle_wait: got v=%b pc=%h inst=%h, want v=0 pc=00000002 inst=00000013",
                     out_valid_o, pc_o, inst_o);
        end
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0001_00A0;
        step();
        fetch_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || pc_o !== 32'h2 || is_compressed_o !== 1'b0) begin
            errors++;
            $display("FAIL straddle_32: got v=%b inst=%h pc=%h c=%b, want v=1 inst=00a00513 pc=00000002 c=0",
                     out_valid_o, inst_o, pc_o, is_compressed_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h0000_0001 || pc_o !== 32'h6 || is_compressed_o !== 1'b1) begin
            errors++;
            $display("FAIL straddle_c1: got v=%b inst=%h pc=%h c=%b, want v=1 inst=00000001 pc=00000006 c=1",
                     out_valid_o, inst_o, pc_o, is_compressed_o);
        end
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h8) begin
            errors++;
            $display("FAIL straddle_drained: got v=%b pc=%h, want v=0 pc=00000008", out_valid_o, pc_o);
        end
    endtask

    task automatic test_misaligned_flush();
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_0103;
        step();
        flush_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h102 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL misflush_idle: got v=%b pc=%h fr=%b, want v=0 pc=00000102 fr=1",
                     out_valid_o, pc_o, fetch_ready_o);
        end
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h4505_FFFF;
        step();
        fetch_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h0000_4505 || pc_o !== 32'h102 || is_compressed_o !== 1'b1) begin
            errors++;
            $display("FAIL misflush_out: got v=%b inst=%h pc=%h c=%b, want v=1 inst=00004505 pc=00000102 c=1",
                     out_valid_o, inst_o, pc_o, is_compressed_o);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h104) begin
            errors++;
            $display("FAIL misflush_drop_low: got v=%b pc=%h, want v=0 pc=00000104", out_valid_o, pc_o);
        end
    endtask

    task automatic test_flush_push_pop();
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h00A0_0513;
        step();
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || pc_o !== 32'h104) begin
            errors++;
            $display("FAIL fpp_preload: got v=%b inst=%h pc=%h, want v=1 inst=00a00513 pc=00000104",
                     out_valid_o, inst_o, pc_o);
        end
        flush_i      = 1'b1;
        flush_pc_i   = 32'h200;
        fetch_data_i = 32'h1234_5678;
        out_ready_i  = 1'b1;
        step();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        out_ready_i   = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || inst_o !== 32'h13 || pc_o !== 32'h200 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL fpp_flush: got v=%b inst=%h pc=%h fr=%b, want v=0 inst=00000013 pc=00000200 fr=1",
                     out_valid_o, inst_o, pc_o, fetch_ready_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h200) begin
            errors++;
            $display("FAIL fpp_beat_dropped: got v=%b pc=%h, want v=0 pc=00000200", out_valid_o, pc_o);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [3];
        words[0] = 32'h00A0_0513;
        words[1] = 32'h00B0_0593;
        words[2] = 32'h00C0_0613;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_valid_i = 1'b1;
            fetch_data_i  = words[i];
            step();
        end
        fetch_data_i = 32'hDEAD_BEEF;
        checks++;
        if (fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: fetch_ready got %b want 0", fetch_ready_o);
        end
        step();
        fetch_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || pc_o !== 32'h200 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v=%b inst=%h pc=%h fr=%b, want v=1 inst=00a00513 pc=00000200 fr=0",
                     out_valid_o, inst_o, pc_o, fetch_ready_o);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (fetch_ready_o !== 1'b1 || inst_o !== 32'h00B0_0593 || pc_o !== 32'h204) begin
            errors++;
            $display("FAIL bp_release: got fr=%b inst=%h pc=%h, want fr=1 inst=00b00593 pc=00000204",
                     fetch_ready_o, inst_o, pc_o);
        end
        out_ready_i = 1'b1;
        step();
        checks++;
        if (inst_o !== 32'h00C0_0613 || pc_o !== 32'h208) begin
            errors++;
            $display("FAIL bp_third: got inst=%h pc=%h, want inst=00c00613 pc=00000208", inst_o, pc_o);
        end
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h20C) begin
            errors++;
            $display("FAIL bp_drained: got v=%b pc=%h, want v=0 pc=0000020c", out_valid_o, pc_o);
        end
    endtask

    task automatic test_async_reset();
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0001_0001;
        step();
        out_ready_i = 1'b1;
        step();
        fetch_valid_i = 1'b0;
        out_ready_i   = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || pc_o !== 32'h20E || inst_o !== 32'h0000_0001) begin
            errors++;
            $display("FAIL ar_preload: got v=%b pc=%h inst=%h, want v=1 pc=0000020e inst=00000001",
                     out_valid_o, pc_o, inst_o);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h13) begin
            errors++;
            $display("FAIL ar_immediate: got v=%b fr=%b pc=%h inst=%h, want v=0 fr=0 pc=00000000 inst=00000013",
                     out_valid_o, fetch_ready_o, pc_o, inst_o);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ar_release: got fr=%b v=%b, want fr=1 v=0", fetch_ready_o, out_valid_o);
        end
        @(negedge clk);
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h00A0_0513;
        step();
        fetch_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || pc_o !== 32'h0 || is_compressed_o !== 1'b0) begin
            errors++;
            $display("FAIL ar_first_push: got v=%b inst=%h pc=%h c=%b, want v=1 inst=00a00513 pc=00000000 c=0",
                     out_valid_o, inst_o, pc_o, is_compressed_o);
        end
    endtask

    initial begin
        reset         = 1'b1;
        flush_i       = 1'b0;
        flush_pc_i    = 32'h0;
        fetch_valid_i = 1'b0;
        fetch_data_i  = 32'h0;
        out_ready_i   = 1'b0;

        test_reset();
        test_aligned();
        test_straddle();
        test_misaligned_flush();
        test_flush_push_pop();
        test_backpressure();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_c_realign_buffer
`default_nettype wire
